hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 1, number of cycles flush_* stay asserted per flush event (legal 1..4).
REQ-002 Parameter: MC_TIMEOUT, default 64, maximum MC_WAIT cycles before forced exit (legal 2..255).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: rs1_id, rs2_id  in  5 each  ID-stage source registers.
REQ-006 Port: rs1_used_id, rs2_used_id  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 Port: id_valid, ex_valid  in  1 each  ID / EX stage holds a valid instruction.
REQ-008 Port: rd_ex  in  5  EX-stage destination register.
REQ-009 Port: mem_read_ex  in  1  EX instruction is a load.
REQ-010 Port: mc_start  in  1  multi-cycle unit (mul/div) starts in EX this cycle.
REQ-011 Port: mc_done  in  1  multi-cycle unit result valid this cycle.
REQ-012 Port: branch_taken_ex  in  1  EX redirect (taken branch/jump).
REQ-013 Port: trap_req  in  1  trap/interrupt redirect request.
REQ-014 Port: stall_if, stall_id, stall_ex  out  1 each  hold PC / IF-ID / ID-EX registers.
REQ-015 Port: bubble_ex  out  1  insert NOP into ID-EX.
REQ-016 Port: flush_if_id, flush_id_ex  out  1 each  invalidate IF-ID / ID-EX.
REQ-017 Port: mc_abort, mc_timeout  out  1 each  one-cycle pulses.
REQ-018 Port: busy  out  1  state != RUN.

Function
REQ-019 States SHALL be RUN, MC_WAIT, FLUSH; request priority SHALL be trap_req > branch_taken_ex > mc_start > load-use.
REQ-020 Load-use SHALL be: RUN && id_valid && ex_valid && mem_read_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)).
REQ-021 On load-use (no higher request) stall_if=stall_id=bubble_ex=1 combinationally for that cycle only; state stays RUN.
REQ-022 On trap_req or branch_taken_ex in RUN, flush_if_id=flush_id_ex=1 in the same cycle; stall_*/bubble_ex SHALL be 0; if FLUSH_CYCLES>1 go to FLUSH with count=FLUSH_CYCLES-1.
REQ-023 In FLUSH, flush outputs SHALL stay 1, count decrements each cycle; at count==1 return to RUN after that cycle; other requests ignored except trap_req, which reloads count.
REQ-024 On mc_start in RUN with mc_done=0, stall_if=stall_id=stall_ex=1 in the same cycle, go to MC_WAIT, timer=0.
REQ-025 mc_start && mc_done in the same cycle SHALL cause no stall and stay in RUN.
REQ-026 In MC_WAIT, stall_if/id/ex SHALL be 1 each cycle mc_done=0; timer increments by 1 per cycle.
REQ-027 In MC_WAIT, mc_done=1 SHALL deassert all stalls that cycle and return to RUN.
REQ-028 In MC_WAIT, timer==MC_TIMEOUT-1 without mc_done SHALL pulse mc_timeout, deassert stalls that cycle, return to RUN.
REQ-029 In MC_WAIT, trap_req SHALL pulse mc_abort, assert flushes, deassert stalls, and proceed per REQ-022; branch_taken_ex SHALL be ignored in MC_WAIT.
REQ-030 Flush and stall outputs SHALL never both be 1 in any cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force state=RUN, count=0, timer=0, mc_abort=mc_timeout=0, busy=0; combinational outputs SHALL follow RUN rules.
REQ-032 Reset mid-MC_WAIT or mid-FLUSH SHALL abandon the operation without mc_abort or mc_timeout pulses.

Configuration
REQ-033 Macro HAZARD_CTRL_PERF_EN defined: add output stall_cycles (32 bits), counting cycles with stall_if=1, saturating at 0xFFFFFFFF, reset to 0.
REQ-034 Macro HAZARD_CTRL_PERF_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-035 rd_ex=5, mem_read_ex=1, rs1_id=5, rs1_used_id=1, both valid -> stall_if/stall_id/bubble_ex=1 for exactly 1 cycle; with rd_ex=0 -> no stall.
REQ-036 mc_start, mc_done after 10 cycles -> stall_ex=1 for cycles 0..9, 0 on cycle 10; busy=1 cycles 1..10.
REQ-037 MC_TIMEOUT=8, mc_done never -> mc_timeout pulses on cycle 8 (MC_WAIT cycle 7), state RUN afterwards.
REQ-038 FLUSH_CYCLES=3, branch_taken_ex with simultaneous load-use -> flush_* =1 for 3 cycles, no stall/bubble.
REQ-039 trap_req in MC_WAIT cycle 4 -> mc_abort 1-cycle pulse, stalls drop, flush asserted; rst_n low mid-FLUSH -> all outputs 0 immediately.
REQ-040 With HAZARD_CTRL_PERF_EN: 1 load-use + 10-cycle mc op -> stall_cycles=11.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for load-use, multi-cycle ops and redirects.
// Optional stall_cycles performance counter is present when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64
) (
`ifdef HAZARD_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_ex,
  input  logic       mc_start,
  input  logic       mc_done,
  input  logic       branch_taken_ex,
  input  logic       trap_req,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       bubble_ex,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       mc_abort,
  output logic       mc_timeout,
  output logic       busy
);
  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;
  localparam logic [1:0] FC_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(MC_TIMEOUT - 1);
  localparam state_t     FLUSH_TO  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  state_t     state, state_nx;
  logic [1:0] count, count_nx;
  logic [7:0] timer, timer_nx;
  logic       load_use, flush;
  assign load_use = id_valid && ex_valid && mem_read_ex && rd_ex != 5'd0 &&
                    ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
  assign flush_if_id = flush;
  assign flush_id_ex = flush;
  assign busy        = state != RUN;
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    timer_nx   = timer;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    bubble_ex  = 1'b0;
    flush      = 1'b0;
    mc_abort   = 1'b0;
    mc_timeout = 1'b0;
    if (state == FLUSH) begin
      flush = 1'b1;
      if (trap_req) count_nx = FC_RELOAD;
      else if (count <= 2'd1) begin
        state_nx = RUN;
        count_nx = 2'd0;
      end else count_nx = count - 2'd1;
    end else if (state == MC_WAIT) begin
      timer_nx = 8'd0;
      if (trap_req) begin
        mc_abort = 1'b1;
        flush    = 1'b1;
        state_nx = FLUSH_TO;
        count_nx = FC_RELOAD;
      end else if (mc_done) state_nx = RUN;
      else if (timer == TMO_LAST) begin
        mc_timeout = 1'b1;
        state_nx   = RUN;
      end else begin
        {stall_if, stall_id, stall_ex} = 3'b111;
        timer_nx = timer + 8'd1;
      end
    end else if (trap_req || branch_taken_ex) begin
      flush    = 1'b1;
      state_nx = FLUSH_TO;
      count_nx = FC_RELOAD;
    end else if (mc_start) begin
      // a unit finishing in its start cycle needs no wait at all
      if (!mc_done) begin
        {stall_if, stall_id, stall_ex} = 3'b111;
        state_nx = MC_WAIT;
        timer_nx = 8'd0;
      end
    end else if (load_use) {stall_if, stall_id, bubble_ex} = 3'b111;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      count <= 2'd0;
      timer <= 8'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      timer <= timer_nx;
    end
  end
`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= 32'd0;
    else if (stall_if && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized scoreboard bench comparing hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int FC  = 3;
  localparam int TMO = 8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic       rs1_used_id = 0, rs2_used_id = 0, id_valid = 0, ex_valid = 0;
  logic       mem_read_ex = 0, mc_start = 0, mc_done = 0, branch_taken_ex = 0, trap_req = 0;
  logic       stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex;
  logic       mc_abort, mc_timeout, busy;
  logic [31:0] stall_cycles;
  typedef struct packed {
    logic [8:0]  o;
    logic [31:0] sc;
  } exp_t;
  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;
  bit   mc_act = 0;
  int   mc_age = 0, flush_rem = 0;
  logic [31:0] perf = '0;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MC_TIMEOUT(TMO)) dut (
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .id_valid(id_valid), .ex_valid(ex_valid), .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .mc_start(mc_start), .mc_done(mc_done), .branch_taken_ex(branch_taken_ex),
    .trap_req(trap_req), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mc_abort(mc_abort), .mc_timeout(mc_timeout), .busy(busy)
  );
`ifndef HAZARD_CTRL_PERF_EN
  assign stall_cycles = '0;
`endif

  always #5 clk = ~clk;

  // Reference: one call per cycle, returns this cycle's outputs and advances the model.
  function automatic exp_t model(input bit rst);
    exp_t e;
    bit s3 = 0, lu3 = 0, fl = 0, ab = 0, to = 0, bz, lu;
    if (rst) begin
      mc_act = 0; mc_age = 0; flush_rem = 0; perf = '0;
    end
    bz = mc_act || flush_rem > 0;
    lu = id_valid && ex_valid && mem_read_ex && rd_ex != 0 &&
         ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
    if (flush_rem > 0) begin
      fl = 1;
      flush_rem = trap_req ? FC - 1 : flush_rem - 1;
    end else if (mc_act) begin
      if (trap_req) begin
        ab = 1; fl = 1; mc_act = 0; flush_rem = FC - 1;
      end else if (mc_done) mc_act = 0;
      else if (mc_age == TMO - 1) begin
        to = 1; mc_act = 0;
      end else begin
        s3 = 1; mc_age++;
      end
    end else if (trap_req || branch_taken_ex) begin
      fl = 1; flush_rem = FC - 1;
    end else if (mc_start) begin
      if (!mc_done) begin
        s3 = 1; mc_act = 1; mc_age = 0;
      end
    end else if (lu) lu3 = 1;
    e.o  = {s3 | lu3, s3 | lu3, s3, lu3, fl, fl, ab, to, bz};
    e.sc = perf;
    if (rst) begin
      mc_act = 0; mc_age = 0; flush_rem = 0;
    end else if (e.o[8] && perf != 32'hFFFF_FFFF) perf++;
    return e;
  endfunction

  initial begin
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      @(posedge clk); #1;
      rst = (i < 2) || ($urandom % 150 == 0);
      rst_n           = !rst;
      rs1_id          = 5'($urandom_range(0, 3));
      rs2_id          = 5'($urandom_range(0, 3));
      rd_ex           = 5'($urandom_range(0, 3));
      rs1_used_id     = 1'($urandom % 2);
      rs2_used_id     = 1'($urandom % 2);
      id_valid        = ($urandom % 8) != 0;
      ex_valid        = ($urandom % 8) != 0;
      mem_read_ex     = 1'($urandom % 2);
      mc_start        = ($urandom % 6) == 0;
      mc_done         = ($urandom % 10) == 0;
      branch_taken_ex = ($urandom % 12) == 0;
      trap_req        = ($urandom % 25) == 0;
      q.push_back(model(rst));
    end
    @(posedge clk); #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: outputs are combinational, so each cycle presents one response.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e   = q.pop_front();
      got = {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex, mc_abort, mc_timeout, busy};
      cyc++;
      tests++;
      if (got !== e.o) begin
        fails++;
        $display("FAIL outputs cyc %0d: got %b required %b (sif sid sex bub fif fex abt tmo busy)", cyc, got, e.o);
      end
      tests++;
      if ((got[8] | got[7] | got[6] | got[5]) & (got[4] | got[3])) begin
        fails++;
        $display("FAIL exclusive cyc %0d: stall/flush both set, got %b", cyc, got);
      end
`ifdef HAZARD_CTRL_PERF_EN
      tests++;
      if (stall_cycles !== e.sc) begin
        fails++;
        $display("FAIL stall_cycles cyc %0d: got %0d required %0d", cyc, stall_cycles, e.sc);
      end
`endif
    end
  end
endmodule
